// File: rtl/ctrl_seq.sv
// Multi-cycle RV32I/Zicsr control sequencer: IFU handshake, registered decode, LSU stall/timeout, commit pulse.
// Optional macro CTRL_SEQ_ILLEGAL_TRAP_EN: trap illegal instructions (cause 2) instead of retiring them as NOPs.
module ctrl_seq #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rd_we,
  output logic        mem_we,
  output logic [2:0]  mem_op,
  output logic [1:0]  rd_in_sel,
  output logic        csr_we,
  output logic [1:0]  csr_op,
  output logic        csr_imm,
  output logic [2:0]  branch_way,
  output logic [1:0]  pc_sel,
  output logic        commit,
  output logic [3:0]  trap_cause,
  output logic        busy
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
  localparam bit ILL_TRAP = 1'b1;
`else
  localparam bit ILL_TRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB, S_TRAP
  } state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       rd_we;
    logic       mem_we;
    logic [2:0] mem_op;
    logic [1:0] rd_in_sel;
    logic       csr_we;
    logic [1:0] csr_op;
    logic       csr_imm;
    logic [2:0] branch_way;
    logic [1:0] pc_sel;
  } ctl_t;

  state_t               r_state, w_nxt;
  logic [31:0]          r_inst;
  ctl_t                 r_ctl, w_dec;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [3:0]           r_cause, w_dcause;
  logic                 w_illegal, w_ecall, w_ebreak, w_mret, w_trap, w_mem, w_timeout;
  logic [6:0]           w_opc, w_f7;
  logic [2:0]           w_f3;

  assign w_opc = r_inst[6:0];
  assign w_f3  = r_inst[14:12];
  assign w_f7  = r_inst[31:25];

  always_comb begin
    w_dec     = '0;
    w_illegal = 1'b0;
    w_ecall   = 1'b0;
    w_ebreak  = 1'b0;
    w_mret    = 1'b0;
    case (w_opc)
      OPC_LUI:   begin w_dec.alu_op = 4'b1111; w_dec.rd_we = 1'b1; end
      OPC_AUIPC: begin w_dec.alu_a_sel = 1'b1; w_dec.rd_we = 1'b1; end
      OPC_JAL:   begin w_dec.alu_a_sel = 1'b1; w_dec.rd_we = 1'b1; w_dec.rd_in_sel = 2'd3; end
      OPC_JALR:  begin w_dec.rd_we = 1'b1; w_dec.rd_in_sel = 2'd3; w_dec.pc_sel = 2'd3; end
      OPC_BRANCH: begin
        w_dec.alu_op     = (w_f3[2:1] == 2'b00) ? 4'b1000 : {1'b0, 2'b01, w_f3[1]};
        w_dec.branch_way = {w_f3[2], w_f3[0], 1'b1};
      end
      OPC_LOAD:  begin w_dec.rd_we = 1'b1; w_dec.mem_op = w_f3; w_dec.rd_in_sel = 2'd1; end
      OPC_STORE: begin w_dec.mem_we = 1'b1; w_dec.mem_op = w_f3; end
      OPC_OPIMM: begin
        w_dec.alu_op = {r_inst[30] & (w_f3 == 3'b101), w_f3};
        w_dec.rd_we  = 1'b1;
      end
      OPC_OP: begin
        // Only sub and sra may use func7 = 0100000
        if (w_f7 == 7'b0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
          w_dec.alu_op = {r_inst[30], w_f3};
          w_dec.rd_we  = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if (w_f3 == 3'b000) begin
          w_ecall  = (r_inst == INST_ECALL);
          w_ebreak = (r_inst == INST_EBREAK);
          w_mret   = (r_inst == INST_MRET);
          if (w_mret) w_dec.pc_sel = 2'd2;
          w_illegal = !(w_ecall | w_ebreak | w_mret);
        end else if (w_f3 == 3'b100) begin
          w_illegal = 1'b1;
        end else begin
          w_dec.rd_we     = 1'b1;
          w_dec.rd_in_sel = 2'd2;
          w_dec.csr_op    = w_f3[1:0];
          w_dec.csr_imm   = w_f3[2];
          w_dec.csr_we    = !(w_f3[1] && r_inst[19:15] == 5'd0);
        end
      end
      default: w_illegal = 1'b1;
    endcase
    w_dec.alu_b_sel = !(w_opc == OPC_OP || w_opc == OPC_BRANCH);
    if (r_inst[11:7] == 5'd0) w_dec.rd_we = 1'b0;
    // Illegal encodings carry an all-zero bundle so they retire as pure NOPs
    if (w_illegal) w_dec = '0;
  end

  assign w_trap    = w_ecall | w_ebreak | (w_illegal & ILL_TRAP);
  assign w_dcause  = w_ecall ? 4'd11 : (w_ebreak ? 4'd3 : 4'd2);
  assign w_mem     = (w_opc == OPC_LOAD) || (w_opc == OPC_STORE);
  assign w_timeout = !lsu_resp_valid && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt         = r_state;
    inst_ready    = 1'b0;
    lsu_req_valid = 1'b0;
    mem_we        = 1'b0;
    rd_we         = 1'b0;
    csr_we        = 1'b0;
    commit        = 1'b0;
    pc_sel        = r_ctl.pc_sel;
    trap_cause    = 4'd0;
    case (r_state)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) w_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_trap)     w_nxt = S_TRAP;
        else if (w_mem) w_nxt = S_MEM_REQ;
        else            w_nxt = S_EXEC;
      end
      S_EXEC: w_nxt = S_WB;
      S_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        mem_we        = r_ctl.mem_we;
        if (lsu_req_ready) w_nxt = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (lsu_resp_valid) w_nxt = S_WB;
        else if (w_timeout) w_nxt = S_TRAP;
      end
      S_WB: begin
        rd_we  = r_ctl.rd_we;
        csr_we = r_ctl.csr_we;
        commit = 1'b1;
        w_nxt  = S_IDLE;
      end
      S_TRAP: begin
        pc_sel     = 2'd1;
        trap_cause = r_cause;
        commit     = 1'b1;
        w_nxt      = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst  <= '0;
      r_ctl   <= '0;
      r_cnt   <= '0;
      r_cause <= '0;
    end else begin
      if (r_state == S_IDLE && inst_valid) r_inst <= inst;
      if (r_state == S_DECODE) begin
        r_ctl   <= w_dec;
        r_cause <= w_dcause;
      end
      if (r_state == S_MEM_REQ && lsu_req_ready) r_cnt <= '0;
      else if (r_state == S_MEM_WAIT && !lsu_resp_valid) r_cnt <= r_cnt + TIMEOUT_W'(1);
      if (r_state == S_MEM_WAIT && w_timeout) r_cause <= 4'd5;
    end
  end

  assign alu_op     = r_ctl.alu_op;
  assign alu_a_sel  = r_ctl.alu_a_sel;
  assign alu_b_sel  = r_ctl.alu_b_sel;
  assign mem_op     = r_ctl.mem_op;
  assign rd_in_sel  = r_ctl.rd_in_sel;
  assign csr_op     = r_ctl.csr_op;
  assign csr_imm    = r_ctl.csr_imm;
  assign branch_way = r_ctl.branch_way;
  assign busy       = (r_state != S_IDLE);

endmodule
